// File: rtl/seq_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and error codes.
package seq_pkg;

    localparam int unsigned ERR_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StResult,
        StError
    } state_t;

    localparam logic [ERR_W-1:0] ErrNone     = 2'd0;
    localparam logic [ERR_W-1:0] ErrTimeout  = 2'd1;
    localparam logic [ERR_W-1:0] ErrSpurious = 2'd2;

endpackage

// File: rtl/seq_watchdog.sv
// Clearable run-time watchdog: counts enabled cycles and flags when the limit is reached.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] Limit = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expired_o = (count_q == Limit);

    // Counter parks at the limit so a stalled stage cannot wrap it back to zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Frame-level sequencer that launches a chain of layer engines one after another,
// supervising each stage with a watchdog and reporting per-frame latency.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned N_STAGES       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned CYCW           = 32,
    localparam int unsigned SW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_valid_i,
    output logic                frame_ready_o,
    output logic [N_STAGES-1:0] stage_start_o,
    input  logic [N_STAGES-1:0] stage_done_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    input  logic                abort_i,
    input  logic                clear_err_i,
    output logic                busy_o,
    output logic                error_o,
    output logic [ERR_W-1:0]    err_code_o,
    output logic [SW-1:0]       err_stage_o,
    output logic [CYCW-1:0]     frame_cycles_o
);

    localparam logic [SW-1:0] LastIdx = SW'(N_STAGES - 1);

    state_t              state_q, state_d;
    logic [SW-1:0]       idx_q, idx_d;
    logic [ERR_W-1:0]    err_code_q, err_code_d;
    logic [SW-1:0]       err_stage_q, err_stage_d;
    logic [CYCW-1:0]     cyc_q, cyc_d;
    logic [N_STAGES-1:0] idx_onehot;
    logic                done_hit, done_stray;
    logic                wd_clr, wd_en, wd_expired;

    assign idx_onehot = N_STAGES'(1) << idx_q;
    assign done_hit   = |(stage_done_i & idx_onehot);
    assign done_stray = |(stage_done_i & ~idx_onehot);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_code_d    = err_code_q;
        err_stage_d   = err_stage_q;
        cyc_d         = cyc_q;
        stage_start_o = '0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;

        if ((state_q inside {StLaunch, StRun}) && (cyc_q != '1)) begin
            cyc_d = cyc_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (frame_valid_i) begin
                    state_d = StLaunch;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            StLaunch: begin
                // The start pulse is issued even if abort cancels the frame this cycle.
                stage_start_o = idx_onehot;
                wd_clr        = 1'b1;
                state_d       = abort_i ? StIdle : StRun;
            end
            StRun: begin
                wd_en = 1'b1;
                // Priority: abort, then a stray done, then the expected done, then timeout.
                if (abort_i) begin
                    state_d = StIdle;
                end else if (done_stray) begin
                    state_d     = StError;
                    err_code_d  = ErrSpurious;
                    err_stage_d = idx_q;
                end else if (done_hit) begin
                    if (idx_q == LastIdx) begin
                        state_d = StResult;
                    end else begin
                        state_d = StLaunch;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d     = StError;
                    err_code_d  = ErrTimeout;
                    err_stage_d = idx_q;
                end
            end
            StResult: begin
                if (abort_i || result_ready_i) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                if (clear_err_i) begin
                    state_d    = StIdle;
                    err_code_d = ErrNone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            err_code_q  <= ErrNone;
            err_stage_q <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_code_q  <= err_code_d;
            err_stage_q <= err_stage_d;
            cyc_q       <= cyc_d;
        end
    end

    assign frame_ready_o  = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = (state_q == StResult);
    assign error_o        = (state_q == StError);
    assign err_code_o     = err_code_q;
    assign err_stage_o    = err_stage_q;
    assign frame_cycles_o = cyc_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized scoreboard bench for layer_sequencer: a stage responder drives done pulses,
// expected results/errors are queued from per-stage latencies and checked by a monitor.
module tb_layer_sequencer;
    import seq_pkg::*;

    localparam int unsigned N   = 3;
    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned SW  = 2;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_valid;
    logic          frame_ready;
    logic [N-1:0]  stage_start;
    logic [N-1:0]  stage_done;
    logic          result_valid;
    logic          result_ready;
    logic          abort;
    logic          clear_err;
    logic          busy;
    logic          error;
    logic [ERR_W-1:0] err_code;
    logic [SW-1:0] err_stage;
    logic [CW-1:0] frame_cycles;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_STAGES      (N),
        .TIMEOUT_CYCLES(TO),
        .CYCW          (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_valid_i (frame_valid),
        .frame_ready_o (frame_ready),
        .stage_start_o (stage_start),
        .stage_done_i  (stage_done),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .abort_i       (abort),
        .clear_err_i   (clear_err),
        .busy_o        (busy),
        .error_o       (error),
        .err_code_o    (err_code),
        .err_stage_o   (err_stage),
        .frame_cycles_o(frame_cycles)
    );

    typedef struct {
        bit is_err;
        int code;
        int stage;
        int cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever a result or an error appears.
    logic rv_prev, err_prev;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            rv_prev  <= 1'b0;
            err_prev <= 1'b0;
        end else begin
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_kind", int'(e.is_err), 0);
                    check("frame_cycles", int'(frame_cycles), e.cycles);
                end
            end
            if (error && !err_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_error", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("error_kind", int'(e.is_err), 1);
                    check("err_code", int'(err_code), e.code);
                    check("err_stage", int'(err_stage), e.stage);
                end
            end
            rv_prev  <= result_valid;
            err_prev <= error;
        end
    end

    task automatic clear_error();
        check("err_flag", int'(error), 1);
        check("err_busy", int'(busy), 1);
        check("err_not_ready", int'(frame_ready), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("err_abort_ignored", int'(error), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("cleared_idle", int'(frame_ready), 1);
        check("err_code_zero", int'(err_code), 0);
    endtask

    // lat[k] is the done latency of stage k (> TO means it never reports done).
    // mode 0: normal, 1: abort at ev_stage with ev_done, 2: drive ev_done (stray) at ev_stage.
    task automatic run_frame(input int lat[N], input int mode, input int ev_stage,
                             input logic [N-1:0] ev_done, input int hold, input bit junk);
        int total;
        total = 0;
        check("idle_ready", int'(frame_ready), 1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("cycles_cleared", int'(frame_cycles), 0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("start_%0d", k), int'(stage_start), 1 << k);
            check("busy", int'(busy), 1);
            if (junk) stage_done = N'($urandom);
            tick();
            stage_done = '0;
            total += 1;
            if (lat[k] > int'(TO)) begin
                repeat (TO - 1) tick();
                check("no_early_timeout", int'(error), 0);
                exp_q.push_back('{1'b1, 1, k, 0});
                tick();
                clear_error();
                return;
            end
            repeat (lat[k] - 1) tick();
            total += lat[k];
            if (mode == 1 && k == ev_stage) begin
                abort      = 1'b1;
                stage_done = ev_done;
                tick();
                abort      = 1'b0;
                stage_done = '0;
                check("abort_idle", int'(frame_ready), 1);
                check("abort_no_result", int'(result_valid), 0);
                return;
            end
            if (mode == 2 && k == ev_stage) begin
                exp_q.push_back('{1'b1, 2, k, 0});
                stage_done = ev_done;
                tick();
                stage_done = '0;
                clear_error();
                return;
            end
            if (k == N - 1) exp_q.push_back('{1'b0, 0, 0, (total > SAT) ? SAT : total});
            stage_done = N'(1 << k);
            tick();
            stage_done = '0;
        end
        for (int h = 0; h < hold; h++) begin
            check("rv_hold", int'(result_valid), 1);
            check("ready_low", int'(frame_ready), 0);
            if (junk) stage_done = N'($urandom);
            tick();
        end
        stage_done = '0;
        check("rv_final", int'(result_valid), 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("idle_after_result", int'(frame_ready), 1);
        check("rv_dropped", int'(result_valid), 0);
    endtask

    initial begin : driver
        int lat[N];
        int mode, evs, other;
        logic [N-1:0] evd;
        reset        = 1'b1;
        frame_valid  = 1'b0;
        stage_done   = '0;
        result_ready = 1'b0;
        abort        = 1'b0;
        clear_err    = 1'b0;
        repeat (3) tick();
        check("rst_start", int'(stage_start), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b0;
        check("rst_ready", int'(frame_ready), 1);
        check("rst_err_code", int'(err_code), 0);
        check("rst_cycles", int'(frame_cycles), 0);

        lat = '{1, 1, 1};
        run_frame(lat, 0, 0, '0, 0, 1'b0);
        lat = '{2, 3, 1};
        run_frame(lat, 0, 0, '0, 5, 1'b0);
        lat = '{1, 20, 1};
        run_frame(lat, 0, 0, '0, 0, 1'b0);
        lat = '{2, 1, 1};
        run_frame(lat, 2, 0, 3'b100, 0, 1'b0);
        lat = '{1, 1, 3};
        run_frame(lat, 1, 2, 3'b100, 0, 1'b0);
        lat = '{1, 2, 1};
        run_frame(lat, 0, 0, '0, 1, 1'b0);

        // Reset during the RUN phase of stage 1.
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        stage_done = 3'b001;
        tick();
        stage_done = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_start", int'(stage_start), 0);
        check("midrst_rv", int'(result_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_error", int'(error), 0);
        check("midrst_ready", int'(frame_ready), 1);
        reset = 1'b0;
        tick();
        check("postrst_ready", int'(frame_ready), 1);
        check("postrst_start", int'(stage_start), 0);

        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < N; k++) begin
                lat[k] = ($urandom_range(0, 11) == 0) ? 17 : int'($urandom_range(1, 6));
            end
            mode  = $urandom_range(0, 9);
            mode  = (mode < 7) ? 0 : ((mode < 9) ? 1 : 2);
            evs   = $urandom_range(0, N - 1);
            other = (evs + 1 + $urandom_range(0, N - 2)) % N;
            evd   = $urandom_range(0, 1) ? N'(1 << evs) : '0;
            if (mode == 2) evd = evd | N'(1 << other);
            // Idle cycle with noise that must be ignored.
            abort      = 1'b1;
            stage_done = N'($urandom);
            tick();
            abort      = 1'b0;
            stage_done = '0;
            check("idle_noise_ignored", int'(busy), 0);
            run_frame(lat, mode, evs, evd, $urandom_range(0, 3), 1'b1);
        end

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
